// File: rtl/jtag_tap_pkg.sv
// Shared TAP definitions: state encoding, instruction opcodes and IR capture pattern.
package jtag_tap_pkg;

  // Standard 1149.1 4-bit state encoding
  typedef logic [3:0] tap_state_t;

  localparam tap_state_t StExit2Dr  = 4'h0;
  localparam tap_state_t StExit1Dr  = 4'h1;
  localparam tap_state_t StShiftDr  = 4'h2;
  localparam tap_state_t StPauseDr  = 4'h3;
  localparam tap_state_t StSelIr    = 4'h4;
  localparam tap_state_t StUpdDr    = 4'h5;
  localparam tap_state_t StCapDr    = 4'h6;
  localparam tap_state_t StSelDr    = 4'h7;
  localparam tap_state_t StExit2Ir  = 4'h8;
  localparam tap_state_t StExit1Ir  = 4'h9;
  localparam tap_state_t StShiftIr  = 4'hA;
  localparam tap_state_t StPauseIr  = 4'hB;
  localparam tap_state_t StRti      = 4'hC;
  localparam tap_state_t StUpdIr    = 4'hD;
  localparam tap_state_t StCapIr    = 4'hE;
  localparam tap_state_t StTlr      = 4'hF;

  typedef enum logic [1:0] {SelBypass, SelIdcode, SelUser, SelUsercode} dr_sel_e;

  localparam logic [9:0] InstrBypass   = 10'h3FF;
  localparam logic [9:0] InstrIdcode   = 10'h059;
  localparam logic [9:0] InstrUser     = 10'h2A0;
  localparam logic [9:0] InstrUsercode = 10'h010;

  localparam logic [1:0] IrCapture = 2'b01;

endpackage

// File: rtl/jtag_tap_fsm.sv
// 16-state TAP controller; emits the current state and per-edge capture/shift/update strobes.
module jtag_tap_fsm
  import jtag_tap_pkg::*;
(
  input  logic       CLK,
  input  logic       AR,
  input  logic       TMS,
  output tap_state_t o_state,
  output logic       o_capture_ir,
  output logic       o_shift_ir,
  output logic       o_update_ir,
  output logic       o_capture_dr,
  output logic       o_shift_dr,
  output logic       o_update_dr,
  output logic       o_enter_tlr
);

  tap_state_t r_state;
  tap_state_t w_next;

  always_comb begin
    w_next = r_state;
    case (r_state)
      StTlr:     w_next = TMS ? StTlr     : StRti;
      StRti:     w_next = TMS ? StSelDr   : StRti;
      StSelDr:   w_next = TMS ? StSelIr   : StCapDr;
      StCapDr:   w_next = TMS ? StExit1Dr : StShiftDr;
      StShiftDr: w_next = TMS ? StExit1Dr : StShiftDr;
      StExit1Dr: w_next = TMS ? StUpdDr   : StPauseDr;
      StPauseDr: w_next = TMS ? StExit2Dr : StPauseDr;
      StExit2Dr: w_next = TMS ? StUpdDr   : StShiftDr;
      StUpdDr:   w_next = TMS ? StSelDr   : StRti;
      StSelIr:   w_next = TMS ? StTlr     : StCapIr;
      StCapIr:   w_next = TMS ? StExit1Ir : StShiftIr;
      StShiftIr: w_next = TMS ? StExit1Ir : StShiftIr;
      StExit1Ir: w_next = TMS ? StUpdIr   : StPauseIr;
      StPauseIr: w_next = TMS ? StExit2Ir : StPauseIr;
      StExit2Ir: w_next = TMS ? StUpdIr   : StShiftIr;
      StUpdIr:   w_next = TMS ? StSelDr   : StRti;
      default:   w_next = StTlr;
    endcase
  end

  always_ff @(posedge CLK or posedge AR) begin
    if (AR) begin
      r_state <= StTlr;
    end else begin
      r_state <= w_next;
    end
  end

  // Capture/shift act on the edge leaving their state; update acts on the edge entering it
  assign o_state      = r_state;
  assign o_capture_ir = (r_state == StCapIr);
  assign o_shift_ir   = (r_state == StShiftIr);
  assign o_capture_dr = (r_state == StCapDr);
  assign o_shift_dr   = (r_state == StShiftDr);
  assign o_update_ir  = (w_next == StUpdIr);
  assign o_update_dr  = (w_next == StUpdDr);
  assign o_enter_tlr  = (w_next == StTlr);

endmodule

// File: rtl/jtag_tap_responder.sv
// TAP responder top: IR, BYPASS/IDCODE/USER data registers and falling-edge TDO.
// Define JTAG_TAP_USERCODE_EN to add the USERCODE instruction and USERCODE_VAL parameter.
module jtag_tap_responder
  import jtag_tap_pkg::*;
#(
  parameter int unsigned IR_WIDTH     = 10,
  parameter logic [31:0] IDCODE_VAL   = 32'h0150203F,
  parameter int unsigned USER_WIDTH   = 16
`ifdef JTAG_TAP_USERCODE_EN
  ,
  parameter logic [31:0] USERCODE_VAL = 32'hFFFFFFFF
`endif
) (
  input  logic                  CLK,
  input  logic                  AR,
  input  logic                  TMS,
  input  logic                  TDI,
  output logic                  TDO,
  output logic                  TDO_EN,
  input  logic [USER_WIDTH-1:0] USER_CAP,
  output logic [USER_WIDTH-1:0] USER_OUT,
  output logic                  USER_STB
);

  localparam logic [IR_WIDTH-1:0] IrIdcode = IR_WIDTH'(InstrIdcode);

  tap_state_t w_state;
  logic w_capture_ir, w_shift_ir, w_update_ir;
  logic w_capture_dr, w_shift_dr, w_update_dr, w_enter_tlr;

  logic [IR_WIDTH-1:0]   r_ir_shift;
  logic [IR_WIDTH-1:0]   r_ir_active;
  logic [31:0]           r_dr;
  logic [USER_WIDTH-1:0] r_user_out;
  logic                  r_user_stb;
  logic                  r_tdo;
  logic                  r_tdo_en;

  dr_sel_e     w_sel;
  logic [4:0]  w_dr_msb;
  logic [31:0] w_dr_cap;
  logic [31:0] w_dr_shifted;
  logic        w_user_upd;

  jtag_tap_fsm u_fsm (
    .CLK          (CLK),
    .AR           (AR),
    .TMS          (TMS),
    .o_state      (w_state),
    .o_capture_ir (w_capture_ir),
    .o_shift_ir   (w_shift_ir),
    .o_update_ir  (w_update_ir),
    .o_capture_dr (w_capture_dr),
    .o_shift_dr   (w_shift_dr),
    .o_update_dr  (w_update_dr),
    .o_enter_tlr  (w_enter_tlr)
  );

  // Unrecognised opcodes fall through to BYPASS
  always_comb begin
    w_sel = SelBypass;
    if (r_ir_active == IrIdcode) begin
      w_sel = SelIdcode;
    end else if (r_ir_active == IR_WIDTH'(InstrUser)) begin
      w_sel = SelUser;
`ifdef JTAG_TAP_USERCODE_EN
    end else if (r_ir_active == IR_WIDTH'(InstrUsercode)) begin
      w_sel = SelUsercode;
`endif
    end
  end

  always_comb begin
    w_dr_msb = 5'd0;
    w_dr_cap = 32'd0;
    case (w_sel)
      SelIdcode: begin
        w_dr_msb = 5'd31;
        w_dr_cap = IDCODE_VAL;
      end
      SelUser: begin
        w_dr_msb = 5'(USER_WIDTH - 1);
        w_dr_cap = 32'(USER_CAP);
      end
`ifdef JTAG_TAP_USERCODE_EN
      SelUsercode: begin
        w_dr_msb = 5'd31;
        w_dr_cap = USERCODE_VAL;
      end
`endif
      default: begin
        w_dr_msb = 5'd0;
        w_dr_cap = 32'd0;
      end
    endcase
  end

  // TDI enters at the selected register's MSB so its length tracks the instruction
  always_comb begin
    w_dr_shifted = r_dr >> 1;
    w_dr_shifted[w_dr_msb] = TDI;
  end

  assign w_user_upd = w_update_dr && (w_sel == SelUser);

  always_ff @(posedge CLK or posedge AR) begin
    if (AR) begin
      r_ir_shift  <= '0;
      r_ir_active <= IrIdcode;
      r_dr        <= '0;
      r_user_out  <= '0;
      r_user_stb  <= 1'b0;
    end else begin
      if (w_capture_ir) begin
        r_ir_shift <= IR_WIDTH'(IrCapture);
      end else if (w_shift_ir) begin
        r_ir_shift <= {TDI, r_ir_shift[IR_WIDTH-1:1]};
      end

      if (w_enter_tlr) begin
        r_ir_active <= IrIdcode;
      end else if (w_update_ir) begin
        r_ir_active <= r_ir_shift;
      end

      if (w_capture_dr) begin
        r_dr <= w_dr_cap;
      end else if (w_shift_dr) begin
        r_dr <= w_dr_shifted;
      end

      r_user_stb <= w_user_upd;
      if (w_user_upd) begin
        r_user_out <= r_dr[USER_WIDTH-1:0];
      end
    end
  end

  always_ff @(negedge CLK or posedge AR) begin
    if (AR) begin
      r_tdo    <= 1'b0;
      r_tdo_en <= 1'b0;
    end else if (w_state == StShiftIr) begin
      r_tdo    <= r_ir_shift[0];
      r_tdo_en <= 1'b1;
    end else if (w_state == StShiftDr) begin
      r_tdo    <= r_dr[0];
      r_tdo_en <= 1'b1;
    end else begin
      r_tdo    <= 1'b0;
      r_tdo_en <= 1'b0;
    end
  end

  assign TDO      = r_tdo;
  assign TDO_EN   = r_tdo_en;
  assign USER_OUT = r_user_out;
  assign USER_STB = r_user_stb;

endmodule

// File: tb/tb_jtag_tap_responder.sv
// Directed bench for jtag_tap_responder: IDCODE, USER, BYPASS, IR capture, reset and pause paths.
module tb_jtag_tap_responder;

  logic        CLK = 1'b0;
  logic        AR;
  logic        TMS;
  logic        TDI;
  logic        TDO;
  logic        TDO_EN;
  logic [15:0] USER_CAP;
  logic [15:0] USER_OUT;
  logic        USER_STB;

  int checks = 0;
  int errors = 0;

  logic [31:0] dout;
  logic        en_ok;
  int          stb_cnt;

  jtag_tap_responder dut (
    .CLK      (CLK),
    .AR       (AR),
    .TMS      (TMS),
    .TDI      (TDI),
    .TDO      (TDO),
    .TDO_EN   (TDO_EN),
    .USER_CAP (USER_CAP),
    .USER_OUT (USER_OUT),
    .USER_STB (USER_STB)
  );

  always #10 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One TCK: drive TMS/TDI, take the rising edge, settle after the falling edge
  task automatic tck(input logic tms, input logic tdi);
    TMS = tms;
    TDI = tdi;
    @(posedge CLK);
    @(negedge CLK);
    #1;
  endtask

  // RTI -> Shift-IR -> Update-IR -> RTI
  task automatic load_ir(input logic [9:0] ir);
    tck(1'b1, 1'b0);
    tck(1'b1, 1'b0);
    tck(1'b0, 1'b0);
    tck(1'b0, 1'b0);
    for (int i = 0; i < 10; i++) tck(i == 9, ir[i]);
    tck(1'b1, 1'b0);
    tck(1'b0, 1'b0);
  endtask

  // RTI -> Shift-DR (n bits) -> Update-DR -> RTI, collecting TDO and strobe count
  task automatic shift_dr(input int n, input logic [31:0] din, output logic [31:0] dq,
                          output logic ok, output int stb);
    dq  = '0;
    ok  = 1'b1;
    stb = 0;
    tck(1'b1, 1'b0);
    tck(1'b0, 1'b0);
    tck(1'b0, 1'b0);
    for (int i = 0; i < n; i++) begin
      dq[i] = TDO;
      if (TDO_EN !== 1'b1) ok = 1'b0;
      if (USER_STB) stb++;
      tck(i == n - 1, din[i]);
    end
    if (USER_STB) stb++;
    tck(1'b1, 1'b0);
    if (USER_STB) stb++;
    tck(1'b0, 1'b0);
    if (USER_STB) stb++;
  endtask

  initial begin
    AR       = 1'b1;
    TMS      = 1'b1;
    TDI      = 1'b0;
    USER_CAP = 16'hA5C3;
    #25;
    chk("rst_tdo_en", 32'(TDO_EN), 32'd0);
    chk("rst_tdo", 32'(TDO), 32'd0);
    chk("rst_user_out", 32'(USER_OUT), 32'd0);
    chk("rst_user_stb", 32'(USER_STB), 32'd0);
    chk("rst_ir", 32'(dut.r_ir_active), 32'h059);
    chk("rst_state", 32'(dut.w_state), 32'hF);
    AR = 1'b0;

    // IDCODE straight out of TLR
    tck(1'b0, 1'b0);
    shift_dr(32, 32'h0, dout, en_ok, stb_cnt);
    chk("idcode_tdo", dout, 32'h0150203F);
    chk("idcode_en", 32'(en_ok), 32'd1);
    chk("idcode_stb", 32'(stb_cnt), 32'd0);
    chk("idle_tdo_en", 32'(TDO_EN), 32'd0);

    // USER exchange
    load_ir(10'h2A0);
    chk("user_ir", 32'(dut.r_ir_active), 32'h2A0);
    shift_dr(16, 32'h1234, dout, en_ok, stb_cnt);
    chk("user_tdo", dout, 32'hA5C3);
    chk("user_out", 32'(USER_OUT), 32'h1234);
    chk("user_stb_cnt", 32'(stb_cnt), 32'd1);

    // Capture -> Exit1 -> Update writes captured value back
    USER_CAP = 16'h0F0F;
    tck(1'b1, 1'b0);
    tck(1'b0, 1'b0);
    tck(1'b1, 1'b0);
    tck(1'b1, 1'b0);
    chk("wb_stb_hi", 32'(USER_STB), 32'd1);
    chk("wb_user_out", 32'(USER_OUT), 32'h0F0F);
    tck(1'b0, 1'b0);
    chk("wb_stb_lo", 32'(USER_STB), 32'd0);

    // Pause mid-shift, resume via Exit2 without recapture
    USER_CAP = 16'h3C5A;
    dout = '0;
    tck(1'b1, 1'b0);
    tck(1'b0, 1'b0);
    tck(1'b0, 1'b0);
    for (int i = 0; i < 8; i++) begin
      dout[i] = TDO;
      tck(i == 7, 1'(16'hBEEF >> i));
    end
    tck(1'b0, 1'b0);
    tck(1'b0, 1'b0);
    chk("pause_tdo_en", 32'(TDO_EN), 32'd0);
    USER_CAP = 16'h0000;
    tck(1'b1, 1'b0);
    tck(1'b0, 1'b0);
    for (int i = 8; i < 16; i++) begin
      dout[i] = TDO;
      tck(i == 15, 1'(16'hBEEF >> i));
    end
    tck(1'b1, 1'b0);
    tck(1'b0, 1'b0);
    chk("pause_tdo", dout, 32'h3C5A);
    chk("pause_user_out", 32'(USER_OUT), 32'hBEEF);

    // Async reset in the middle of Shift-DR
    tck(1'b1, 1'b0);
    tck(1'b0, 1'b0);
    tck(1'b0, 1'b0);
    tck(1'b0, 1'b1);
    tck(1'b0, 1'b1);
    chk("ar_pre_en", 32'(TDO_EN), 32'd1);
    AR = 1'b1;
    #2;
    chk("ar_async_en", 32'(TDO_EN), 32'd0);
    chk("ar_async_out", 32'(USER_OUT), 32'd0);
    chk("ar_async_ir", 32'(dut.r_ir_active), 32'h059);
    AR = 1'b0;
    for (int i = 0; i < 5; i++) tck(1'b1, 1'b0);
    chk("ar_state", 32'(dut.w_state), 32'hF);
    chk("ar_tdo_en", 32'(TDO_EN), 32'd0);
    chk("ar_ir", 32'(dut.r_ir_active), 32'h059);
    chk("ar_user_out", 32'(USER_OUT), 32'd0);

    // Unknown opcode behaves as BYPASS
    tck(1'b0, 1'b0);
    load_ir(10'h155);
    shift_dr(4, 32'b1101, dout, en_ok, stb_cnt);
    chk("byp_tdo", dout, 32'hA);
    chk("byp_stb", 32'(stb_cnt), 32'd0);
    chk("byp_user_out", 32'(USER_OUT), 32'd0);

    // IR capture pattern, then five TMS=1 from Pause-IR
    tck(1'b1, 1'b0);
    tck(1'b1, 1'b0);
    tck(1'b0, 1'b0);
    tck(1'b0, 1'b0);
    dout = '0;
    for (int i = 0; i < 12; i++) begin
      dout[i] = TDO;
      tck(1'b0, 1'b0);
    end
    chk("ir_cap_tdo", dout, 32'h001);
    chk("ir_cap_en", 32'(TDO_EN), 32'd1);
    tck(1'b1, 1'b0);
    tck(1'b0, 1'b0);
    chk("pause_ir_state", 32'(dut.w_state), 32'hB);
    for (int i = 0; i < 5; i++) tck(1'b1, 1'b0);
    chk("tlr_state", 32'(dut.w_state), 32'hF);
    chk("tlr_ir", 32'(dut.r_ir_active), 32'h059);

    // USERCODE opcode
    tck(1'b0, 1'b0);
    load_ir(10'h010);
    chk("uc_ir", 32'(dut.r_ir_active), 32'h010);
    shift_dr(32, 32'h80000003, dout, en_ok, stb_cnt);
`ifdef JTAG_TAP_USERCODE_EN
    chk("uc_tdo", dout, 32'hFFFFFFFF);
`else
    chk("uc_tdo", dout, 32'h00000006);
`endif
    chk("uc_stb", 32'(stb_cnt), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
